reduction_accum_unit: RTL



---
 rtl/reduction_pkg.sv | 42 ++++
 rtl/reduction_tree.sv | 35 +++
 rtl/reduction_accum_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reduction_pkg.sv
// Shared constants, group-state encoding and saturation helpers for the
// reduction/accumulate unit.
package reduction_pkg;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Widest result the saturation helpers can describe; callers narrow it.
    localparam int unsigned SAT_W = 64;

    typedef enum logic {
        GRP_IDLE,
        GRP_OPEN
    } grp_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [SAT_W-1:0] sat_max(input int unsigned width, input logic mode);
        logic [SAT_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SAT_W; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        if (mode == MODE_SIGNED) v[width-1] = 1'b0;
        return v;
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int unsigned width, input logic mode);
        logic [SAT_W-1:0] v;
        v = '0;
        if (mode == MODE_SIGNED) v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reduction_tree.sv
// Combinational pairwise adder tree: extends LANES values of IN_W bits to
// SUM_W bits (signed or unsigned) and sums them.
module reduction_tree
    import reduction_pkg::*;
#(
    parameter  int unsigned LANES = 4,
    parameter  int unsigned IN_W  = 9,
    localparam int unsigned SUM_W = IN_W + clog2(LANES)
) (
    input  logic [LANES*IN_W-1:0] p_i,
    input  logic                  signed_i,
    output logic [SUM_W-1:0]      sum_o
);

    localparam int unsigned LEVELS = clog2(LANES);
    localparam int unsigned EXT_W  = SUM_W - IN_W;

    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
        localparam int unsigned N = LANES >> lv;
        logic [SUM_W-1:0] v [N];

        if (lv == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_ext
                assign v[i] = {{EXT_W{signed_i & p_i[i*IN_W+IN_W-1]}}, p_i[i*IN_W +: IN_W]};
            end
        end else begin : g_add
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign v[i] = g_lvl[lv-1].v[2*i] + g_lvl[lv-1].v[2*i+1];
            end
        end
    end

    assign sum_o = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/reduction_accum_unit.sv
// Two-stage SAD/dot reduction back end: per-lane A+B, tree sum, optional
// saturating accumulation across beat groups, valid/ready on both sides.
module reduction_accum_unit
    import reduction_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ELEM_W-1:0] A,
    input  logic [LANES*ELEM_W-1:0] B,
    input  logic                    mode,
    input  logic                    acc_en,
    input  logic                    last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        S,
    output logic                    ovf
);

    localparam int unsigned P_W   = ELEM_W + 1;
    localparam int unsigned SUM_W = P_W + clog2(LANES);
    localparam int unsigned X_W   = OUT_W + 1;

    logic en;
    logic accept;

    grp_state_e grp_q, grp_d;
    logic       grp_mode_q, grp_mode_d;
    logic       eff_mode;

    logic                 s1_valid_q;
    logic [LANES*P_W-1:0] s1_p_q, s1_p_d;
    logic                 s1_mode_q, s1_acc_q, s1_last_q;
    logic [P_W-1:0]       a_e, b_e;

    logic [SUM_W-1:0] sum;
    logic [X_W-1:0]   sum_x, acc_x, nxt;
    logic             nxt_ovf;
    logic [OUT_W-1:0] nxt_sat, smax, smin;

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] s_q, s_d;
    logic             sticky_q, sticky_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Group mode is resolved at acceptance so stage 1 already extends later
    // beats of a group with the mode latched on its first beat.
    always_comb begin
        grp_d      = grp_q;
        grp_mode_d = grp_mode_q;
        eff_mode   = mode;
        if (accept && acc_en) begin
            case (grp_q)
                GRP_IDLE: begin
                    if (!last) begin
                        grp_d      = GRP_OPEN;
                        grp_mode_d = mode;
                    end
                end
                GRP_OPEN: begin
                    eff_mode = grp_mode_q;
                    if (last) grp_d = GRP_IDLE;
                end
                default: grp_d = GRP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q      <= GRP_IDLE;
            grp_mode_q <= MODE_UNSIGNED;
        end else begin
            grp_q      <= grp_d;
            grp_mode_q <= grp_mode_d;
        end
    end

    always_comb begin
        s1_p_d = '0;
        a_e    = '0;
        b_e    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a_e = {eff_mode & A[i*ELEM_W+ELEM_W-1], A[i*ELEM_W +: ELEM_W]};
            b_e = {eff_mode & B[i*ELEM_W+ELEM_W-1], B[i*ELEM_W +: ELEM_W]};
            s1_p_d[i*P_W +: P_W] = a_e + b_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_mode_q  <= MODE_UNSIGNED;
            s1_acc_q   <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_p_q     <= s1_p_d;
            s1_mode_q  <= eff_mode;
            s1_acc_q   <= acc_en;
            s1_last_q  <= last;
        end
    end

    reduction_tree #(
        .LANES (LANES),
        .IN_W  (P_W)
    ) u_tree (
        .p_i      (s1_p_q),
        .signed_i (s1_mode_q),
        .sum_o    (sum)
    );

    always_comb begin
        sum_x = s1_mode_q ? {{(X_W-SUM_W){sum[SUM_W-1]}}, sum}
                          : {{(X_W-SUM_W){1'b0}}, sum};
        acc_x = s1_mode_q ? {acc_q[OUT_W-1], acc_q} : {1'b0, acc_q};
        nxt   = acc_x + sum_x;
        smax  = OUT_W'(sat_max(OUT_W, s1_mode_q));
        smin  = OUT_W'(sat_min(OUT_W, s1_mode_q));
        if (s1_mode_q == MODE_SIGNED) nxt_ovf = nxt[OUT_W] ^ nxt[OUT_W-1];
        else                          nxt_ovf = nxt[OUT_W];
        if (!nxt_ovf)                        nxt_sat = nxt[OUT_W-1:0];
        else if (s1_mode_q && nxt[OUT_W])    nxt_sat = smin;
        else                                 nxt_sat = smax;
    end

    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        s_d         = s_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (s1_valid_q) begin
                if (!s1_acc_q) begin
                    s_d         = sum_x[OUT_W-1:0];
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                end else if (s1_last_q) begin
                    s_d         = nxt_sat;
                    ovf_d       = sticky_q | nxt_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = nxt_sat;
                    sticky_d = sticky_q | nxt_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            s_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            s_q         <= s_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign ovf       = ovf_q;

endmodule
